// File: rtl/pipe_stage_fifo_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_fifo_pkg
//   Shared definitions for the generic pipeline stage buffer:
//   - PIPE_DEPTH_MAX : largest supported buffer depth.
//   - IDEX_*         : ID/EX payload field offsets/widths, so the ID stage
//                      packs and the EX stage unpacks the same layout.
//   - idex_payload_t : the same layout as a packed struct.
//   - ptr_w()        : pointer width for a given depth (minimum 1 bit).
// -----------------------------------------------------------------------------
package pipe_stage_fifo_pkg;

    localparam int PIPE_DEPTH_MAX = 4;

    // ID/EX payload packing, LSB first.
    localparam int IDEX_OPA_LSB  = 0;
    localparam int IDEX_OPA_W    = 32;
    localparam int IDEX_OPB_LSB  = IDEX_OPA_LSB + IDEX_OPA_W;
    localparam int IDEX_OPB_W    = 32;
    localparam int IDEX_CTRL_LSB = IDEX_OPB_LSB + IDEX_OPB_W;
    localparam int IDEX_CTRL_W   = 32;
    localparam int IDEX_MEM_LSB  = IDEX_CTRL_LSB + IDEX_CTRL_W;
    localparam int IDEX_MEM_W    = 32;
    localparam int IDEX_CSR_LSB  = IDEX_MEM_LSB + IDEX_MEM_W;
    localparam int IDEX_CSR_W    = 32;
    localparam int IDEX_W        = IDEX_CSR_LSB + IDEX_CSR_W;

    typedef struct packed {
        logic [IDEX_CSR_W-1:0]  csr;
        logic [IDEX_MEM_W-1:0]  mem;
        logic [IDEX_CTRL_W-1:0] ctrl;
        logic [IDEX_OPB_W-1:0]  op_b;
        logic [IDEX_OPA_W-1:0]  op_a;
    } idex_payload_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_ptr.sv
// -----------------------------------------------------------------------------
// pipe_stage_ptr
//   Wrap-around pointer incrementer for a DEPTH-entry circular buffer.
//   Wraps DEPTH-1 -> 0 by compare, so non-power-of-2 depths work.
//   Ports:
//     ptr_i      : current pointer
//     ptr_next_o : pointer + 1, modulo DEPTH
// -----------------------------------------------------------------------------
module pipe_stage_ptr
    import pipe_stage_fifo_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = ptr_w(DEPTH)
) (
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] ptr_next_o
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    assign ptr_next_o = (ptr_i == LAST) ? '0 : ptr_i + PW'(1);

endmodule

// File: rtl/pipe_stage_fifo.sv
// -----------------------------------------------------------------------------
// pipe_stage_fifo
//   Generic pipeline stage buffer: DEPTH-entry elastic buffer carrying an
//   opaque DATA_W-bit payload with valid/ready on both sides, plus the flow
//   control unit's stall (freeze everything) and flush (empty to bubbles).
//   Priority per clock: rst > fc_stall_i > fc_flush_i > push/pop.
//   There is no full pass-through: up_ready_o never depends on dn_ready_i.
//
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     up_valid_i   : upstream presents a payload
//     up_data_i    : upstream payload
//     up_ready_o   : stage accepts this cycle
//     dn_valid_o   : head entry valid toward downstream
//     dn_data_o    : head payload, straight from storage
//     dn_ready_i   : downstream consumes the head this cycle
//     fc_stall_i   : hold all state
//     fc_flush_i   : discard all entries
//     occ_o        : current entry count
//   Optional (macro PIPE_STAGE_PERF_EN):
//     stall_cnt_o  : saturating count of cycles with fc_stall_i=1
//     full_cnt_o   : saturating count of cycles full with up_valid_i=1
// -----------------------------------------------------------------------------
module pipe_stage_fifo
    import pipe_stage_fifo_pkg::*;
#(
    parameter  int DATA_W       = 160,
    parameter  int DEPTH        = 2,
    parameter  bit CLR_ON_FLUSH = 1'b1,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              up_ready_o,
    output logic              dn_valid_o,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              dn_ready_i,
    input  logic              fc_stall_i,
    input  logic              fc_flush_i,
    output logic [CW-1:0]     occ_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       full_cnt_o
`endif
);

    localparam int PW = ptr_w(DEPTH);

    if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
        $error("pipe_stage_fifo: DEPTH must be 1..%0d", PIPE_DEPTH_MAX);
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;

    pipe_stage_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .ptr_i      (wr_ptr_q),
        .ptr_next_o (wr_ptr_nxt)
    );

    pipe_stage_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .ptr_i      (rd_ptr_q),
        .ptr_next_o (rd_ptr_nxt)
    );

    // Ready is based on the registered count only, so a full stage does not
    // reopen on a same-cycle pop.
    assign up_ready_o = (count_q != CW'(DEPTH)) && !fc_stall_i && !fc_flush_i;
    assign dn_valid_o = (count_q != '0) && !fc_stall_i;
    assign dn_data_o  = mem_q[rd_ptr_q];
    assign occ_o      = count_q;

    // Both events are already masked by stall/flush through the handshakes.
    assign push = up_valid_i && up_ready_o;
    assign pop  = dn_valid_o && dn_ready_i && !fc_flush_i;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!fc_stall_i) begin
            if (fc_flush_i) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push) wr_ptr_d = wr_ptr_nxt;
                if (pop)  rd_ptr_d = rd_ptr_nxt;
                count_d = count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from pre-edge values regardless of block order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: storage is reset here only because dn_data_o is read straight
        // from it and must show zero after reset; a plain data RAM would not be.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (!fc_stall_i && fc_flush_i && CLR_ON_FLUSH) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= up_data_i;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] full_cnt_q;

    // Performance counters saturate and survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            if (fc_stall_i && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if ((count_q == CW'(DEPTH)) && up_valid_i && (full_cnt_q != 32'hFFFF_FFFF))
                full_cnt_q <= full_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign full_cnt_o  = full_cnt_q;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
module tb_pipe_stage_fifo;

    localparam int DW = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT 0: DEPTH=2
    logic          uv0, ur0, dv0, rdy0, st0, fl0;
    logic [DW-1:0] ud0, dd0;
    logic [1:0]    occ0;
    // DUT 1: DEPTH=3
    logic          uv1, ur1, dv1, rdy1, st1, fl1;
    logic [DW-1:0] ud1, dd1;
    logic [1:0]    occ1;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   sc0, fc0, sc1, fc1;
`endif

    pipe_stage_fifo #(.DATA_W(DW), .DEPTH(2), .CLR_ON_FLUSH(1'b1)) u0 (
        .clk(clk), .rst(rst),
        .up_valid_i(uv0), .up_data_i(ud0), .up_ready_o(ur0),
        .dn_valid_o(dv0), .dn_data_o(dd0), .dn_ready_i(rdy0),
        .fc_stall_i(st0), .fc_flush_i(fl0), .occ_o(occ0)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(sc0), .full_cnt_o(fc0)
`endif
    );

    pipe_stage_fifo #(.DATA_W(DW), .DEPTH(3), .CLR_ON_FLUSH(1'b1)) u1 (
        .clk(clk), .rst(rst),
        .up_valid_i(uv1), .up_data_i(ud1), .up_ready_o(ur1),
        .dn_valid_o(dv1), .dn_data_o(dd1), .dn_ready_i(rdy1),
        .fc_stall_i(st1), .fc_flush_i(fl1), .occ_o(occ1)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(sc1), .full_cnt_o(fc1)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboards: payloads in acceptance order, popped when delivered.
    logic [DW-1:0] sb0[$];
    logic [DW-1:0] sb1[$];
    int del0 = 0, del1 = 0, pushed1 = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model step, evaluated at the negedge with settled inputs.
    task automatic mon(input int id, input int depth,
                       input logic uv, input logic [DW-1:0] ud, input logic ur,
                       input logic dv, input logic [DW-1:0] dd, input logic rdy,
                       input logic st, input logic fl, input int occ);
        int            sz;
        logic [DW-1:0] head;
        logic          exp_ur, exp_dv;
        sz   = (id == 0) ? sb0.size() : sb1.size();
        head = '0;
        if (sz != 0) head = (id == 0) ? sb0[0] : sb1[0];
        exp_ur = (sz != depth) && !st && !fl;
        exp_dv = (sz != 0) && !st;
        check($sformatf("u%0d up_ready", id), DW'(ur), DW'(exp_ur));
        check($sformatf("u%0d dn_valid", id), DW'(dv), DW'(exp_dv));
        check($sformatf("u%0d occ", id), DW'(occ), DW'(sz));
        check($sformatf("u%0d occ_bound", id), DW'(occ <= depth), DW'(1));
        if (exp_dv) check($sformatf("u%0d dn_data", id), dd, head);
        if (!st) begin
            if (fl) begin
                if (id == 0) sb0.delete(); else sb1.delete();
            end else begin
                if (exp_dv && rdy) begin
                    if (id == 0) begin void'(sb0.pop_front()); del0++; end
                    else begin void'(sb1.pop_front()); del1++; end
                end
                if (uv && exp_ur) begin
                    if (id == 0) sb0.push_back(ud);
                    else begin sb1.push_back(ud); pushed1++; end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb0.delete();
            sb1.delete();
        end else begin
            mon(0, 2, uv0, ud0, ur0, dv0, dd0, rdy0, st0, fl0, int'(occ0));
            mon(1, 3, uv1, ud1, ur1, dv1, dd1, rdy1, st1, fl1, int'(occ1));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    typedef struct {
        logic       uv;
        logic [7:0] d;
        logic       rdy;
        int         occ;
        logic       dv;
        logic       ur;
        logic       chk_d;
        logic [7:0] dd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d_snap;
        // Fill/drain on DEPTH=2 with pre-edge expectations.
        vecs[0] = '{1'b1, 8'h11, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'h11};
        vecs[2] = '{1'b1, 8'h33, 1'b0, 2, 1'b1, 1'b0, 1'b1, 8'h11};
        vecs[3] = '{1'b1, 8'h33, 1'b0, 2, 1'b1, 1'b0, 1'b1, 8'h11};
        vecs[4] = '{1'b1, 8'h33, 1'b1, 2, 1'b1, 1'b0, 1'b1, 8'h11};
        vecs[5] = '{1'b1, 8'h33, 1'b1, 1, 1'b1, 1'b1, 1'b1, 8'h22};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 1'b1, 8'h33};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00};

        uv0 = 1'b1; ud0 = DW'(8'hA5); rdy0 = 1'b0; st0 = 1'b0; fl0 = 1'b0;
        uv1 = 1'b0; ud1 = '0;         rdy1 = 1'b0; st1 = 1'b0; fl1 = 1'b0;

        // Reset held 2 cycles with a valid upstream payload.
        rst = 1'b1;
        repeat (2) begin
            tick();
            check("rst dn_valid", DW'(dv0), DW'(0));
            check("rst dn_data", dd0, '0);
            check("rst occ", DW'(occ0), DW'(0));
        end
        rst = 1'b0;
        uv0 = 1'b0;
        #1;
        check("post_rst up_ready", DW'(ur0), DW'(1));

        // Table-driven fill/drain.
        for (int i = 0; i < 8; i++) begin
            uv0  = vecs[i].uv;
            ud0  = DW'(vecs[i].d);
            rdy0 = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d occ", i), DW'(occ0), DW'(vecs[i].occ));
            check($sformatf("vec%0d dn_valid", i), DW'(dv0), DW'(vecs[i].dv));
            check($sformatf("vec%0d up_ready", i), DW'(ur0), DW'(vecs[i].ur));
            if (vecs[i].chk_d) check($sformatf("vec%0d dn_data", i), dd0, DW'(vecs[i].dd));
            tick();
        end

        // Streaming 1..8 with downstream always ready.
        d_snap = del0;
        uv0 = 1'b1; rdy0 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            ud0 = DW'(k);
            #1;
            if (k >= 2) begin
                check("stream occ", DW'(occ0), DW'(1));
                check("stream dn_data", dd0, DW'(k - 1));
            end
            tick();
        end
        uv0 = 1'b0;
        #1;
        check("stream last", dd0, DW'(8));
        tick();
        check("stream delivered", DW'(del0 - d_snap), DW'(8));
        check("stream empty", DW'(occ0), DW'(0));

        // Stall dominates flush.
        rdy0 = 1'b0; uv0 = 1'b1;
        ud0 = DW'(8'h55); tick();
        ud0 = DW'(8'h66); tick();
        uv0 = 1'b0; st0 = 1'b1; fl0 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall occ", DW'(occ0), DW'(2));
            check("stall dn_valid", DW'(dv0), DW'(0));
            check("stall dn_data", dd0, DW'(8'h55));
            check("stall up_ready", DW'(ur0), DW'(0));
            tick();
        end
        st0 = 1'b0;
        tick();
        fl0 = 1'b0;
        #1;
        check("flush occ", DW'(occ0), DW'(0));
        check("flush dn_valid", DW'(dv0), DW'(0));
        check("flush dn_data", dd0, '0);

        // Flush drops a same-cycle push.
        fl0 = 1'b1; uv0 = 1'b1; ud0 = DW'(8'h44);
        #1;
        check("flush_push up_ready", DW'(ur0), DW'(0));
        tick();
        fl0 = 1'b0; ud0 = DW'(8'h77);
        #1;
        check("post_flush up_ready", DW'(ur0), DW'(1));
        tick();
        uv0 = 1'b0; rdy0 = 1'b1;
        #1;
        check("post_flush dn_valid", DW'(dv0), DW'(1));
        check("post_flush dn_data", dd0, DW'(8'h77));
        tick();
        rdy0 = 1'b0;
        #1;
        check("post_flush occ", DW'(occ0), DW'(0));

        // Pointer wrap on DEPTH=3 with 1-cycle dn_ready gaps.
        uv1 = 1'b1;
        for (int cyc = 0; cyc < 60 && pushed1 < 10; cyc++) begin
            ud1  = DW'(32'h100 + pushed1);
            rdy1 = (cyc < 3) ? 1'b0 : ((cyc % 2) == 1);
            #1;
            if (cyc == 3) check("wrap full occ", DW'(occ1), DW'(3));
            tick();
        end
        check("wrap pushed", DW'(pushed1), DW'(10));
        uv1 = 1'b0; rdy1 = 1'b1;
        for (int cyc = 0; cyc < 10 && sb1.size() != 0; cyc++) tick();
        check("wrap delivered", DW'(del1), DW'(10));
        check("wrap empty", DW'(occ1), DW'(0));
        rdy1 = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
